remote_cmd_link: RTL and testbench
==================================

// Module: remote_cmd_link
// PURPOSE
//  Host-side command link: serialises a CMD_BYTES-wide command MSB-byte-first over UART,
//  then waits a bounded time for a one-byte response. Successor to the fixed 2-byte sender.
//  Adds a width parameter, a response timeout with error flag, and optional retransmission.
//  Sits between the remote/test host logic and the TX/RX pins of the follower link.
// PARAMETERS
//  CMD_BYTES     2      bytes per command (>=1); cmd width = 8*CMD_BYTES
//  BAUD_DIV      2604   clk cycles per UART bit, passed to uart_core
//  RESP_TIMEOUT  50000  clk cycles allowed in WAIT_RESP before timeout (>=2)
//  MAX_RETRIES   2      retransmissions after timeout (used only with retry macro)
// PORTS
//  clk          in   1              system clock, all logic on posedge
//  rst_n        in   1              synchronous active-low reset
//  send_cmd     in   1              1-cycle request; accepted only when busy=0
//  cmd          in   8*CMD_BYTES    command word, sampled on the accepting edge
//  RX           in   1              UART serial in
//  TX           out  1              UART serial out, idles high
//  resp         out  8              last response byte received
//  resp_rdy     out  1              resp valid; sticky until next accepted send_cmd
//  cmd_sent     out  1              all bytes of the first attempt transmitted
//  busy         out  1              high in every state except IDLE
//  timeout_err  out  1              no response within the timeout (after retries); sticky
//  retry_cnt    out  $clog2(MAX_RETRIES+1)  retransmissions made for the current command
// BEHAVIOUR
//  Reset: state=IDLE, TX=1, resp=0, resp_rdy=0, cmd_sent=0, busy=0, timeout_err=0, retry_cnt=0.
//  States: IDLE, LOAD, SEND, WAIT_TX, WAIT_RESP.
//  IDLE:  send_cmd=1 -> capture cmd into cmd_hold and shift reg; clear resp_rdy, cmd_sent,
//         timeout_err and retry_cnt; byte index=0; go LOAD.
//         rx_rdy in IDLE (unsolicited byte) -> resp updated, resp_rdy=1.
//  LOAD:  1 cycle; goes to SEND. Re-entered on retry, reloading the shift reg from cmd_hold.
//  SEND:  trmt pulsed exactly 1 cycle with tx_data = shift_reg[top byte]; go WAIT_TX.
//  WAIT_TX: on tx_done, if index < CMD_BYTES-1: shift left 8, index++, go SEND.
//           Otherwise: set cmd_sent on that edge (first attempt only; stays 1), clear timer,
//           clear rx_rdy in uart_core, go WAIT_RESP.
//  WAIT_RESP: timer++ each cycle. rx_rdy -> resp=rx_data, resp_rdy=1, clr_rx_rdy pulsed, go IDLE.
//           rx_rdy and timer==RESP_TIMEOUT-1 in the same cycle -> the response wins.
//           timer==RESP_TIMEOUT-1 without rx_rdy -> timeout handling (CONFIGURATION).
//  send_cmd while busy=1 is ignored: no queueing, cmd not sampled.
//  Bytes go out back to back: at most 2 idle cycles between a tx_done and the next start bit.
//  Latency: accepting edge -> first trmt = 2 cycles.
//  Mid-operation reset (rst_n low at any edge) aborts the frame; all outputs return to reset
//  values on that edge and TX is forced high.
//  CMD_BYTES=1: WAIT_TX goes directly to WAIT_RESP after the single byte.
// CONFIGURATION
//  Macro REMOTE_CMD_LINK_RETRY_EN.
//  Defined: on timeout with retry_cnt < MAX_RETRIES -> retry_cnt++, go LOAD and resend the
//    whole command. Otherwise set timeout_err and go IDLE.
//  Undefined: on timeout, set timeout_err and go IDLE immediately. retry_cnt is tied to 0.
//    MAX_RETRIES is unused.
// STRUCTURE
//  remote_cmd_link_pkg: state enum (link_state_t), default constants
//    (DEF_BAUD_DIV, DEF_RESP_TIMEOUT), byte width localparam.
//  Sub-module uart_core (params BAUD_DIV; synchronous active-low reset).
//    Ports: trmt/tx_data/tx_done, rx_rdy/clr_rx_rdy/rx_data.
//  Top level holds the FSM, shift register, byte index, timeout timer and retry counter.
// TESTING  (BAUD_DIV=8, RESP_TIMEOUT=400, MAX_RETRIES=2)
//  1. cmd=16'hA55A, send_cmd -> TX frames 0xA5 then 0x5A; cmd_sent=1 after the 2nd tx_done.
//     BFM answers 0xC3 -> resp=8'hC3, resp_rdy=1, busy=0.
//  2. CMD_BYTES=3, cmd=24'h123456 -> bytes 0x12,0x34,0x56 in order; cmd_sent only after 0x56.
//  3. No response, macro undefined -> timeout_err=1 exactly 400 cycles after entering WAIT_RESP.
//     resp_rdy=0.
//  4. No response, macro defined -> command sent 3 times total, retry_cnt=2, then timeout_err=1.
//     Response on the 2nd attempt -> resp_rdy=1, timeout_err=0, retry_cnt=1.
//  5. send_cmd pulsed again mid-transmission with cmd=16'hFFFF -> ignored.
//     The original frame completes unchanged.
//  6. rst_n low during the 2nd byte -> next edge: TX=1, busy=0, cmd_sent=0.
//     A new send_cmd afterwards completes normally.

Source files
------------

// File: rtl/remote_cmd_link_pkg.sv
// Shared types and defaults for the remote command link.
package remote_cmd_link_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned DEF_BAUD_DIV     = 2604;
    localparam int unsigned DEF_RESP_TIMEOUT = 50000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_TX,
        WAIT_RESP
    } link_state_t;

endpackage

// File: rtl/remote_cmd_link_uart.sv
// uart_core: 8N1 transmitter and receiver at BAUD_DIV clocks per bit.
// tx_done pulses for one cycle after the stop bit; rx_rdy holds until clr_rx_rdy.
module uart_core
    import remote_cmd_link_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trmt,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_done,
    output logic              TX,
    input  logic              RX,
    input  logic              clr_rx_rdy,
    output logic              rx_rdy,
    output logic [BYTE_W-1:0] rx_data
);

    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0] FULL = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF = BAUD_W'(BAUD_DIV / 2 - 1);

    logic              tx_busy_q, tx_done_q;
    logic [9:0]        tx_shift_q;
    logic [BAUD_W-1:0] tx_cnt_q;
    logic [3:0]        tx_bit_q;

    logic              rx_s1_q, rx_s2_q, rx_busy_q, rx_rdy_q;
    logic [BAUD_W-1:0] rx_cnt_q;
    logic [3:0]        rx_bit_q;
    logic [BYTE_W-1:0] rx_shift_q, rx_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_done_q <= 1'b0;
            if (!tx_busy_q) begin
                if (trmt) begin
                    tx_busy_q  <= 1'b1;
                    tx_shift_q <= {1'b1, tx_data, 1'b0};
                    tx_cnt_q   <= FULL;
                    tx_bit_q   <= '0;
                end
            end else if (tx_cnt_q != '0) begin
                tx_cnt_q <= tx_cnt_q - BAUD_W'(1);
            end else begin
                tx_cnt_q   <= FULL;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_done_q <= 1'b1;
                end
            end
        end
    end

    // The half-bit first count lands every later sample near mid-bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_rdy_q   <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
            if (clr_rx_rdy) begin
                rx_rdy_q <= 1'b0;
            end
            if (!rx_busy_q) begin
                if (!rx_s2_q) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= HALF;
                    rx_bit_q  <= '0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - BAUD_W'(1);
            end else begin
                rx_cnt_q <= FULL;
                rx_bit_q <= rx_bit_q + 4'd1;
                if (rx_bit_q == 4'd0) begin
                    if (rx_s2_q) begin
                        rx_busy_q <= 1'b0;
                    end
                end else if (rx_bit_q == 4'd9) begin
                    rx_busy_q <= 1'b0;
                    if (rx_s2_q) begin
                        rx_data_q <= rx_shift_q;
                        rx_rdy_q  <= 1'b1;
                    end
                end else begin
                    rx_shift_q <= {rx_s2_q, rx_shift_q[BYTE_W-1:1]};
                end
            end
        end
    end

    assign TX      = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign tx_done = tx_done_q;
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_data_q;

endmodule

// File: rtl/remote_cmd_link.sv
// Host command link: sends a CMD_BYTES command MSB byte first, then waits for a 1-byte reply.
// Optional resend-on-timeout is enabled by defining REMOTE_CMD_LINK_RETRY_EN.
module remote_cmd_link
    import remote_cmd_link_pkg::*;
#(
    parameter int unsigned CMD_BYTES    = 2,
    parameter int unsigned BAUD_DIV     = DEF_BAUD_DIV,
    parameter int unsigned RESP_TIMEOUT = DEF_RESP_TIMEOUT,
    parameter int unsigned MAX_RETRIES  = 2,
    localparam int unsigned RC_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
    localparam int unsigned CMD_W = BYTE_W * CMD_BYTES
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              send_cmd,
    input  logic [CMD_W-1:0]  cmd,
    input  logic              RX,
    output logic              TX,
    output logic [BYTE_W-1:0] resp,
    output logic              resp_rdy,
    output logic              cmd_sent,
    output logic              busy,
    output logic              timeout_err,
    output logic [RC_W-1:0]   retry_cnt
);

    localparam int unsigned TMR_W = $clog2(RESP_TIMEOUT);
    localparam int unsigned IDX_W = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;

    link_state_t       state_q, state_d;
    logic [CMD_W-1:0]  cmd_hold_q, cmd_hold_d, shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [BYTE_W-1:0] resp_q, resp_d;
    logic              resp_rdy_q, resp_rdy_d;
    logic              cmd_sent_q, cmd_sent_d;
    logic              terr_q, terr_d;
    logic              trmt, tx_done, rx_rdy, clr_rx_rdy;
    logic [BYTE_W-1:0] rx_data;
`ifdef REMOTE_CMD_LINK_RETRY_EN
    logic [RC_W-1:0]   retry_q, retry_d;
`endif

    uart_core #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .trmt       (trmt),
        .tx_data    (shift_q[CMD_W-1 -: BYTE_W]),
        .tx_done    (tx_done),
        .TX         (TX),
        .RX         (RX),
        .clr_rx_rdy (clr_rx_rdy),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_hold_q <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
            cmd_sent_q <= 1'b0;
            terr_q     <= 1'b0;
`ifdef REMOTE_CMD_LINK_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_hold_q <= cmd_hold_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
            cmd_sent_q <= cmd_sent_d;
            terr_q     <= terr_d;
`ifdef REMOTE_CMD_LINK_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_hold_d = cmd_hold_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;
        cmd_sent_d = cmd_sent_q;
        terr_d     = terr_q;
        trmt       = 1'b0;
        clr_rx_rdy = 1'b0;
`ifdef REMOTE_CMD_LINK_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (send_cmd) begin
                    cmd_hold_d = cmd;
                    shift_d    = cmd;
                    idx_d      = '0;
                    resp_rdy_d = 1'b0;
                    cmd_sent_d = 1'b0;
                    terr_d     = 1'b0;
`ifdef REMOTE_CMD_LINK_RETRY_EN
                    retry_d    = '0;
`endif
                    state_d    = LOAD;
                end else if (rx_rdy) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    clr_rx_rdy = 1'b1;
                end
            end
            // Reloading from cmd_hold makes a resend identical to the first attempt.
            LOAD: begin
                shift_d = cmd_hold_q;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                trmt    = 1'b1;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done) begin
                    if (idx_q != IDX_W'(CMD_BYTES - 1)) begin
                        shift_d = shift_q << BYTE_W;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SEND;
                    end else begin
                        cmd_sent_d = 1'b1;
                        timer_d    = '0;
                        clr_rx_rdy = 1'b1;
                        state_d    = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                timer_d = timer_q + TMR_W'(1);
                if (rx_rdy) begin
                    resp_d     = rx_data;
                    resp_rdy_d = 1'b1;
                    clr_rx_rdy = 1'b1;
                    state_d    = IDLE;
                end else if (timer_q == TMR_W'(RESP_TIMEOUT - 1)) begin
`ifdef REMOTE_CMD_LINK_RETRY_EN
                    if (retry_q < RC_W'(MAX_RETRIES)) begin
                        retry_d = retry_q + RC_W'(1);
                        state_d = LOAD;
                    end else begin
                        terr_d  = 1'b1;
                        state_d = IDLE;
                    end
`else
                    terr_d  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp        = resp_q;
    assign resp_rdy    = resp_rdy_q;
    assign cmd_sent    = cmd_sent_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
`ifdef REMOTE_CMD_LINK_RETRY_EN
    assign retry_cnt   = retry_q;
`else
    assign retry_cnt   = '0;
`endif

endmodule

// File: tb/tb_remote_cmd_link.sv
// Directed bench: a 2-byte and a 3-byte link share clock and reset; UART frames are decoded/driven by the bench.
module tb_remote_cmd_link;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send2 = 1'b0, send3 = 1'b0;
    logic [15:0] cmd2 = '0;
    logic [23:0] cmd3 = '0;
    logic        rx2 = 1'b1, rx3 = 1'b1;
    logic        tx2, tx3;
    logic [7:0]  resp2, resp3;
    logic        resp_rdy2, resp_rdy3, cmd_sent2, cmd_sent3, busy2, busy3, terr2, terr3;
    logic [1:0]  rcnt2, rcnt3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    remote_cmd_link #(.CMD_BYTES(2), .BAUD_DIV(8), .RESP_TIMEOUT(400), .MAX_RETRIES(2)) dut (
        .clk(clk), .rst_n(rst_n), .send_cmd(send2), .cmd(cmd2), .RX(rx2), .TX(tx2),
        .resp(resp2), .resp_rdy(resp_rdy2), .cmd_sent(cmd_sent2), .busy(busy2),
        .timeout_err(terr2), .retry_cnt(rcnt2)
    );

    remote_cmd_link #(.CMD_BYTES(3), .BAUD_DIV(8), .RESP_TIMEOUT(400), .MAX_RETRIES(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .send_cmd(send3), .cmd(cmd3), .RX(rx3), .TX(tx3),
        .resp(resp3), .resp_rdy(resp_rdy3), .cmd_sent(cmd_sent3), .busy(busy3),
        .timeout_err(terr3), .retry_cnt(rcnt3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_send(input bit sel, input logic [23:0] c);
        @(negedge clk);
        if (sel) begin cmd3 = c; send3 = 1'b1; end
        else begin cmd2 = c[15:0]; send2 = 1'b1; end
        @(negedge clk);
        send2 = 1'b0;
        send3 = 1'b0;
    endtask

    // Returns at mid stop bit; lat counts negedges until the start bit was seen.
    task automatic rx_byte(input bit sel, output logic [7:0] b, output int lat);
        int n;
        b   = 'x;
        lat = -1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sel ? tx3 : tx2) !== 1'b0 && n < 1000);
        if ((sel ? tx3 : tx2) !== 1'b0) return;
        lat = n;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(negedge clk);
            b[i] = sel ? tx3 : tx2;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic uart_send(input bit sel, input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sel) rx3 = f[i];
            else rx2 = f[i];
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic wait_sent2();
        for (int n = 0; n < 50 && !cmd_sent2; n++) @(negedge clk);
    endtask

    task automatic wait_resp2();
        for (int n = 0; n < 50 && !resp_rdy2; n++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int lat;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx2, 1);
        chk("rst_busy", busy2, 0);
        chk("rst_resp", resp2, 0);
        chk("rst_resp_rdy", resp_rdy2, 0);
        chk("rst_cmd_sent", cmd_sent2, 0);
        chk("rst_terr", terr2, 0);
        chk("rst_retry", rcnt2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2-byte command with reply
        pulse_send(0, 24'h00A55A);
        rx_byte(0, b, lat);
        chk("t1_lat", lat, 2);
        chk("t1_byte0", b, 8'hA5);
        chk("t1_sent_early", cmd_sent2, 0);
        rx_byte(0, b, lat);
        chk("t1_byte1", b, 8'h5A);
        wait_sent2();
        chk("t1_cmd_sent", cmd_sent2, 1);
        chk("t1_busy_wait", busy2, 1);
        uart_send(0, 8'hC3);
        wait_resp2();
        chk("t1_resp_rdy", resp_rdy2, 1);
        chk("t1_resp", resp2, 8'hC3);
        @(negedge clk);
        chk("t1_busy", busy2, 0);
        chk("t1_terr", terr2, 0);

        // unsolicited byte while idle
        uart_send(0, 8'h99);
        wait_resp2();
        repeat (2) @(negedge clk);
        chk("unsol_resp", resp2, 8'h99);
        chk("unsol_busy", busy2, 0);

        // 3-byte command
        pulse_send(1, 24'h123456);
        rx_byte(1, b, lat);
        chk("t2_byte0", b, 8'h12);
        rx_byte(1, b, lat);
        chk("t2_byte1", b, 8'h34);
        chk("t2_sent_early", cmd_sent3, 0);
        rx_byte(1, b, lat);
        chk("t2_byte2", b, 8'h56);
        for (int n = 0; n < 50 && !cmd_sent3; n++) @(negedge clk);
        chk("t2_cmd_sent", cmd_sent3, 1);
        uart_send(1, 8'hA1);
        for (int n = 0; n < 50 && !resp_rdy3; n++) @(negedge clk);
        chk("t2_resp", resp3, 8'hA1);
        chk("t2_resp_rdy", resp_rdy3, 1);

        // no reply: exact timeout point
        pulse_send(0, 24'h000F0F);
        chk("t3_resp_rdy_clr", resp_rdy2, 0);
        rx_byte(0, b, lat);
        chk("t3_byte0", b, 8'h0F);
        rx_byte(0, b, lat);
        chk("t3_byte1", b, 8'h0F);
        wait_sent2();
        repeat (399) @(negedge clk);
        chk("t3_terr_early", terr2, 0);
        chk("t3_busy_early", busy2, 1);
        @(negedge clk);
`ifdef REMOTE_CMD_LINK_RETRY_EN
        chk("t4_retry1", rcnt2, 1);
        chk("t4_terr_r1", terr2, 0);
        chk("t4_busy_r1", busy2, 1);
        for (int a = 1; a < 3; a++) begin
            rx_byte(0, b, lat);
            chk("t4_rs_byte0", b, 8'h0F);
            rx_byte(0, b, lat);
            chk("t4_rs_byte1", b, 8'h0F);
        end
        for (int n = 0; n < 1000 && !terr2; n++) @(negedge clk);
        chk("t4_terr", terr2, 1);
        chk("t4_retry2", rcnt2, 2);
        chk("t4_busy", busy2, 0);
        chk("t4_resp_rdy", resp_rdy2, 0);

        // reply arrives on the second attempt
        pulse_send(0, 24'h0000B2);
        rx_byte(0, b, lat);
        rx_byte(0, b, lat);
        for (int n = 0; n < 1000 && rcnt2 != 2'd1; n++) @(negedge clk);
        rx_byte(0, b, lat);
        chk("t4b_byte0", b, 8'h00);
        rx_byte(0, b, lat);
        chk("t4b_byte1", b, 8'hB2);
        uart_send(0, 8'h5E);
        wait_resp2();
        chk("t4b_resp_rdy", resp_rdy2, 1);
        chk("t4b_resp", resp2, 8'h5E);
        chk("t4b_terr", terr2, 0);
        chk("t4b_retry", rcnt2, 1);
`else
        chk("t3_terr", terr2, 1);
        chk("t3_busy", busy2, 0);
        chk("t3_resp_rdy", resp_rdy2, 0);
        chk("t3_retry", rcnt2, 0);
`endif
        repeat (4) @(negedge clk);

        // send_cmd while busy is ignored
        pulse_send(0, 24'h00A55A);
        rx_byte(0, b, lat);
        chk("t5_byte0", b, 8'hA5);
        pulse_send(0, 24'h00FFFF);
        rx_byte(0, b, lat);
        chk("t5_byte1", b, 8'h5A);
        wait_sent2();
        chk("t5_cmd_sent", cmd_sent2, 1);
        uart_send(0, 8'h3C);
        wait_resp2();
        chk("t5_resp", resp2, 8'h3C);
        repeat (20) @(negedge clk);
        chk("t5_no_resend", busy2, 0);

        // reset during the second byte
        pulse_send(0, 24'h001234);
        rx_byte(0, b, lat);
        chk("t6_byte0", b, 8'h12);
        repeat (20) @(negedge clk);
        chk("t6_tx_low_mid", tx2, (8'h34 >> 1) & 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_tx", tx2, 1);
        chk("t6_rst_busy", busy2, 0);
        chk("t6_rst_cmd_sent", cmd_sent2, 0);
        chk("t6_rst_resp_rdy", resp_rdy2, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse_send(0, 24'h00BEEF);
        rx_byte(0, b, lat);
        chk("t6_new_byte0", b, 8'hBE);
        rx_byte(0, b, lat);
        chk("t6_new_byte1", b, 8'hEF);
        wait_sent2();
        chk("t6_new_sent", cmd_sent2, 1);
        uart_send(0, 8'h77);
        wait_resp2();
        chk("t6_new_resp", resp2, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
